// File: rtl/rojobot_pkg.sv
// Shared definitions for the Rojobot autopilot: register map, FSM states, sensor/BotCtrl layout.
// Latency: n/a (types, constants and a pure combinational steering function).
// Backpressure: n/a.
package rojobot_pkg;

  // Register offsets inside the rojobot window, added to BASE_ADR
  localparam logic [31:0] OFS_BOTINFO  = 32'h0000_000C;
  localparam logic [31:0] OFS_BOTCTRL  = 32'h0000_0010;
  localparam logic [31:0] OFS_UPDTSYNC = 32'h0000_0014;
  localparam logic [31:0] OFS_INTACK   = 32'h0000_0018;

  // Sensors byte lives in BotInfo[15:8]
  localparam int SENS_LSB = 8;

  // BotCtrl field positions and wheel direction encoding
  localparam int  CTRL_L_DIR = 7;
  localparam int  CTRL_R_DIR = 3;
  localparam logic DIR_FWD   = 1'b1;
  localparam logic DIR_REV   = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    INFO,
    CTRL,
    ACKSET,
    ACKCLR,
    WAIT
  } state_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       prox_l;
    logic       prox_r;
    logic       line_l;
    logic       line_c;
    logic       line_r;
  } sensors_t;

  typedef struct packed {
    logic       l_dir;
    logic [2:0] l_spd;
    logic       r_dir;
    logic [2:0] r_spd;
  } botctrl_t;

  // Steering decision: obstacles stop the bot, centre line drives straight,
  // a single side sensor steers toward it, and a lost line spins in place.
  function automatic botctrl_t decide(input sensors_t s,
                                      input logic [2:0] fwd,
                                      input logic [2:0] turn);
    botctrl_t c;
    c = '0;
    if (s.prox_l || s.prox_r) begin
      c = '0;
    end else if (s.line_c) begin
      c.l_dir = DIR_FWD; c.l_spd = fwd;  c.r_dir = DIR_FWD; c.r_spd = fwd;
    end else if (s.line_l && !s.line_r) begin
      c.l_dir = DIR_FWD; c.l_spd = turn; c.r_dir = DIR_FWD; c.r_spd = fwd;
    end else if (s.line_r && !s.line_l) begin
      c.l_dir = DIR_FWD; c.l_spd = fwd;  c.r_dir = DIR_FWD; c.r_spd = turn;
    end else begin
      c.l_dir = DIR_REV; c.l_spd = turn; c.r_dir = DIR_FWD; c.r_spd = turn;
    end
    return c;
  endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single-transaction WISHBONE classic master with ack timeout.
// Latency: cyc/stb rise one clock after start; done is combinational on the ack/err/timeout clock.
// Backpressure: start is ignored while a cycle is open; slave stalls are bounded by ACK_TIMEOUT clocks.
module wb_master_port #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic [7:0] tmo_cnt;
  logic       tmo;

  // Full-word, classic single cycles only
  assign wb_sel_o = 4'hF;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  // Timeout fires on the last allowed clock so cyc is high exactly ACK_TIMEOUT clocks
  assign tmo   = wb_cyc_o && (tmo_cnt == ACK_TIMEOUT - 8'd1);
  assign done  = wb_cyc_o && (wb_ack_i || wb_err_i || tmo);
  // A real ack on the final clock wins over the timeout; a slave error always counts as error
  assign err   = wb_cyc_o && (wb_err_i || (tmo && !wb_ack_i));
  assign rdata = wb_dat_i;

  // Open a cycle on start, hold request stable, close on ack/err/timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      tmo_cnt  <= '0;
    end else if (!wb_cyc_o) begin
      tmo_cnt <= '0;
      if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= we;
        wb_adr_o <= addr;
        wb_dat_o <= wdata;
      end
    end else if (done) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rojobot_autopilot.sv
// Line-following autopilot: polls UpdtSync, reads BotInfo, writes BotCtrl, pulses IntAck.
// Latency: one bus cycle per register access with one idle clock between cycles; POLL_GAP clocks between failed polls.
// Backpressure: waits on the slave ack for up to ACK_TIMEOUT clocks, then flags bus_err and backs off.
module rojobot_autopilot
  import rojobot_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter logic [2:0]  FWD_SPD     = 3'd4,
  parameter logic [2:0]  TURN_SPD    = 3'd2,
  parameter logic [15:0] POLL_GAP    = 16'd1000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy,
  output logic        bus_err,
  output logic [31:0] bot_info,
  output logic [7:0]  motctl,
  output logic [15:0] upd_cnt
);

  state_t      state, next_state;
  logic [15:0] wait_cnt;
  logic        is_bus;
  logic        start;
  logic [31:0] req_adr;
  logic        req_we;
  logic [31:0] req_dat;
  logic        eng_done;
  logic        eng_err;
  logic [31:0] eng_rdata;
  botctrl_t    ctrl_val;

  assign busy     = (state != IDLE);
  assign is_bus   = (state == POLL) || (state == INFO) || (state == CTRL) ||
                    (state == ACKSET) || (state == ACKCLR);
  assign ctrl_val = decide(sensors_t'(bot_info[SENS_LSB +: 8]), FWD_SPD, TURN_SPD);

  wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .addr     (req_adr),
    .we       (req_we),
    .wdata    (req_dat),
    .done     (eng_done),
    .rdata    (eng_rdata),
    .err      (eng_err),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_cti_o (wb_cti_o),
    .wb_bte_o (wb_bte_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-state bus request; a new cycle only starts while en is high
  always_comb begin
    next_state = state;
    req_adr    = BASE_ADR;
    req_we     = 1'b0;
    req_dat    = '0;
    start      = is_bus && en && !wb_cyc_o;

    case (state)
      POLL:    req_adr = BASE_ADR + OFS_UPDTSYNC;
      INFO:    req_adr = BASE_ADR + OFS_BOTINFO;
      CTRL:    begin req_adr = BASE_ADR + OFS_BOTCTRL; req_we = 1'b1; req_dat = {24'd0, ctrl_val}; end
      ACKSET:  begin req_adr = BASE_ADR + OFS_INTACK;  req_we = 1'b1; req_dat = 32'd1; end
      ACKCLR:  begin req_adr = BASE_ADR + OFS_INTACK;  req_we = 1'b1; req_dat = 32'd0; end
      default: ;
    endcase

    case (state)
      IDLE: if (en) next_state = POLL;
      WAIT: begin
        if (!en)                              next_state = IDLE;
        else if (wait_cnt == POLL_GAP - 16'd1) next_state = POLL;
      end
      default: begin
        if (!wb_cyc_o) begin
          // Between cycles: a dropped enable stops before the next access
          if (!en) next_state = IDLE;
        end else if (eng_done) begin
          if (eng_err) begin
            next_state = WAIT;
          end else begin
            case (state)
              POLL:    next_state = eng_rdata[0] ? INFO : WAIT;
              INFO:    next_state = CTRL;
              CTRL:    next_state = ACKSET;
              ACKSET:  next_state = ACKCLR;
              ACKCLR:  next_state = POLL;
              default: next_state = IDLE;
            endcase
          end
          if (!en) next_state = IDLE;
        end
      end
    endcase
  end

  // Results of completed cycles, sticky error flag and poll back-off counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bot_info <= '0;
      motctl   <= '0;
      upd_cnt  <= '0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      else               wait_cnt <= '0;

      if (eng_done) begin
        if (eng_err) begin
          bus_err <= 1'b1;
        end else begin
          case (state)
            INFO:    bot_info <= eng_rdata;
            CTRL:    motctl   <= wb_dat_o[7:0];
            ACKCLR:  upd_cnt  <= upd_cnt + 16'd1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rojobot_autopilot.sv
// Directed bench for rojobot_autopilot with a behavioural WISHBONE slave.
// Latency: slave acks after a programmable number of clocks, or never, or with err.
// Backpressure: slave latency and no-ack mode exercise the master's stall and timeout handling.
module tb_rojobot_autopilot;
  import rojobot_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_A000;
  localparam logic [15:0] GAP  = 16'd20;
  localparam logic [7:0]  TMO  = 8'd16;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, bot_info;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, busy, bus_err;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [7:0]  motctl;
  logic [15:0] upd_cnt;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  always #5 clk = ~clk;

  rojobot_autopilot #(
    .BASE_ADR(BASE), .FWD_SPD(3'd4), .TURN_SPD(3'd2), .POLL_GAP(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .bus_err(bus_err), .bot_info(bot_info), .motctl(motctl), .upd_cnt(upd_cnt)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  typedef struct {
    logic [7:0] sens;
    logic [7:0] ctrl;
  } vec_t;

  txn_t        txn_q[$];
  int          slv_mode = 0;   // 0 ack, 1 never ack, 2 err
  int          slv_lat  = 0;
  int          slv_wait = 0;
  logic        slv_updt = 1'b0;
  logic [31:0] slv_info = '0;
  int          n_pass   = 0;
  int          n_total  = 0;

  // Slave responds on the falling edge so the master samples it on the next rising edge
  always @(negedge clk) begin
    txn_t t;
    if (!rstn) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      slv_wait = 0;
    end else if (wb_ack_i || wb_err_i) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end else if (wb_cyc_o && wb_stb_o && slv_mode != 1) begin
      if (slv_wait >= slv_lat) begin
        slv_wait = 0;
        if (slv_mode == 2) begin
          wb_err_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          if (wb_adr_o == BASE + OFS_UPDTSYNC)     wb_dat_i = {31'd0, slv_updt};
          else if (wb_adr_o == BASE + OFS_BOTINFO) wb_dat_i = slv_info;
          else                                     wb_dat_i = 32'hDEAD_BEEF;
          t.adr = wb_adr_o;
          t.we  = wb_we_o;
          t.dat = wb_dat_o;
          txn_q.push_back(t);
        end
      end else begin
        slv_wait++;
      end
    end else begin
      slv_wait = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input logic lvl, input int budget, input string name);
    int k = 0;
    while (wb_cyc_o !== lvl && k < budget) begin tick(); k++; end
    check(name, 32'(wb_cyc_o === lvl), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(); k++; end
    check(name, 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic wait_upd(input logic [15:0] c0, input int budget, input string name);
    int k = 0;
    while (upd_cnt === c0 && k < budget) begin tick(); k++; end
    check(name, 32'(upd_cnt !== c0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cyc"},      32'(wb_cyc_o), 32'd0);
    check({tag, " stb"},      32'(wb_stb_o), 32'd0);
    check({tag, " we"},       32'(wb_we_o),  32'd0);
    check({tag, " adr"},      wb_adr_o,      32'd0);
    check({tag, " dat"},      wb_dat_o,      32'd0);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " bot_info"}, bot_info,      32'd0);
    check({tag, " motctl"},   32'(motctl),   32'd0);
    check({tag, " upd_cnt"},  32'(upd_cnt),  32'd0);
    check({tag, " bus_err"},  32'(bus_err),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] exp_adr[5];
    logic        exp_we[5];
    logic [31:0] exp_dat[5];
    int          base, gap, hi, k;
    logic [15:0] c0;
    logic [31:0] info;

    // Sensors byte -> BotCtrl with FWD=4, TURN=2 ({dir,spd} per wheel, left nibble first)
    vecs[0] = '{8'h02, 8'hCC};  // centre: both forward at 4
    vecs[1] = '{8'h08, 8'h00};  // proximity bit3: stop
    vecs[2] = '{8'h10, 8'h00};  // proximity bit4: stop
    vecs[3] = '{8'h00, 8'h2A};  // line lost: left reverse 2, right forward 2
    vecs[4] = '{8'h04, 8'hAC};  // left only: left 2, right 4
    vecs[5] = '{8'h01, 8'hCA};  // right only: left 4, right 2
    vecs[6] = '{8'h1A, 8'h00};  // proximity beats centre line
    vecs[7] = '{8'hE7, 8'hCC};  // reserved bits ignored, centre set

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset sel", 32'(wb_sel_o), 32'hF);
    check("reset cti", 32'(wb_cti_o), 32'd0);
    check("reset bte", 32'(wb_bte_o), 32'd0);
    rstn = 1'b1;
    tick(); tick();
    check("idle with en low", 32'(busy), 32'd0);

    // Full update cycles driven from the vector table
    exp_adr[0] = BASE + OFS_UPDTSYNC; exp_we[0] = 1'b0; exp_dat[0] = 32'd0;
    exp_adr[1] = BASE + OFS_BOTINFO;  exp_we[1] = 1'b0; exp_dat[1] = 32'd0;
    exp_adr[2] = BASE + OFS_BOTCTRL;  exp_we[2] = 1'b1;
    exp_adr[3] = BASE + OFS_INTACK;   exp_we[3] = 1'b1; exp_dat[3] = 32'd1;
    exp_adr[4] = BASE + OFS_INTACK;   exp_we[4] = 1'b1; exp_dat[4] = 32'd0;
    for (int i = 0; i < 8; i++) begin
      info       = {16'h1020, vecs[i].sens, 8'h00};
      exp_dat[2] = {24'd0, vecs[i].ctrl};
      slv_mode = 0; slv_lat = i % 3; slv_updt = 1'b1; slv_info = info;
      base = txn_q.size(); c0 = upd_cnt; en = 1'b1;
      wait_upd(c0, 200, $sformatf("vec%0d update done", i));
      en = 1'b0;
      tick(); tick();
      check($sformatf("vec%0d txn count", i), 32'(txn_q.size() - base), 32'd5);
      if (txn_q.size() >= base + 5) begin
        for (int j = 0; j < 5; j++) begin
          check($sformatf("vec%0d txn%0d adr", i, j), txn_q[base+j].adr, exp_adr[j]);
          check($sformatf("vec%0d txn%0d we", i, j), 32'(txn_q[base+j].we), 32'(exp_we[j]));
          if (exp_we[j]) check($sformatf("vec%0d txn%0d dat", i, j), txn_q[base+j].dat, exp_dat[j]);
        end
      end
      check($sformatf("vec%0d motctl", i),   32'(motctl),  32'(vecs[i].ctrl));
      check($sformatf("vec%0d bot_info", i), bot_info,     info);
      check($sformatf("vec%0d upd_cnt", i),  32'(upd_cnt), 32'(i + 1));
      check($sformatf("vec%0d busy", i),     32'(busy),    32'd0);
    end

    // Unsuccessful poll: back off POLL_GAP clocks in WAIT plus one request clock, then poll again
    slv_mode = 0; slv_lat = 0; slv_updt = 1'b0;
    base = txn_q.size(); en = 1'b1;
    wait_cyc(1'b1, 20, "poll1 start");
    check("poll1 adr", wb_adr_o, BASE + OFS_UPDTSYNC);
    check("poll1 we", 32'(wb_we_o), 32'd0);
    wait_cyc(1'b0, 20, "poll1 end");
    gap = 0;
    while (!wb_cyc_o && gap < 200) begin gap++; tick(); end
    check("poll gap clocks", 32'(gap), 32'(GAP) + 32'd1);
    check("poll2 adr", wb_adr_o, BASE + OFS_UPDTSYNC);
    check("single poll before gap", 32'(txn_q.size() - base), 32'd1);
    check("busy while polling", 32'(busy), 32'd1);
    en = 1'b0;
    wait_idle(20, "poll test idle");

    // Enable drops during the BotInfo read: read completes, nothing more is issued
    slv_mode = 0; slv_lat = 3; slv_updt = 1'b1; slv_info = 32'hABCD_0400;
    base = txn_q.size(); en = 1'b1;
    k = 0;
    while (!(wb_cyc_o && wb_adr_o == BASE + OFS_BOTINFO) && k < 100) begin tick(); k++; end
    check("info read seen", 32'(wb_cyc_o && wb_adr_o == BASE + OFS_BOTINFO), 32'd1);
    en = 1'b0;
    wait_cyc(1'b0, 20, "info read end");
    check("en-drop bot_info", bot_info, 32'hABCD_0400);
    check("en-drop busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("en-drop txn count", 32'(txn_q.size() - base), 32'd2);
    check("en-drop cyc", 32'(wb_cyc_o), 32'd0);
    check("en-drop motctl", 32'(motctl), 32'(vecs[7].ctrl));

    // Slave never acks: cycle held ACK_TIMEOUT clocks, then sticky error and back-off
    slv_mode = 1; en = 1'b1;
    wait_cyc(1'b1, 20, "timeout start");
    hi = 0;
    while (wb_cyc_o && hi < 100) begin hi++; tick(); end
    check("timeout cyc clocks", 32'(hi), 32'(TMO));
    check("timeout stb", 32'(wb_stb_o), 32'd0);
    check("timeout bus_err", 32'(bus_err), 32'd1);
    check("timeout state", 32'(dut.state), 32'(WAIT));
    check("timeout busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    check("wait exits on en low", 32'(busy), 32'd0);

    // Reset while a cycle is open
    en = 1'b1;
    wait_cyc(1'b1, 20, "reset-mid start");
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("reset-mid");
    en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Slave error response: cycle ends, data discarded, error flagged
    slv_mode = 2; slv_lat = 1; slv_info = 32'h5555_0200; slv_updt = 1'b1;
    en = 1'b1;
    wait_cyc(1'b1, 20, "err start");
    wait_cyc(1'b0, 20, "err end");
    check("err bus_err", 32'(bus_err), 32'd1);
    check("err bot_info", bot_info, 32'd0);
    check("err upd_cnt", 32'(upd_cnt), 32'd0);
    check("err state", 32'(dut.state), 32'(WAIT));
    en = 1'b0;
    wait_idle(20, "err idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
